// File: rtl/dm_responder.sv
// Memory side of the CPU data-memory interface: one load/store at a time over
// a req/ready handshake, with programmable wait states and sub-word access.
//
// state  | meaning
// IDLE   | waiting for req; latches the request when it arrives
// WAIT   | counting down wait states before the access
// RESP   | ready=1 for one cycle with dout/err valid
module dm_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic [2:0]        digit,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [2:0]        digit_q;
    logic [31:0]       dout_q;
    logic              err_q;
    logic              latch, access;

    logic [31:0] mem [0:DEPTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, so it
    // must use the live inputs rather than the not-yet-latched copies.
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_din;
    logic [2:0]        a_digit;

    assign a_we    = (state_q == S_IDLE) ? we    : we_q;
    assign a_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    assign a_din   = (state_q == S_IDLE) ? din   : din_q;
    assign a_digit = (state_q == S_IDLE) ? digit : digit_q;

    logic [ADDR_W-3:0] widx;
    logic [1:0]        lane;
    logic [31:0]       word, ld_val, wmask, wval;
    logic [15:0]       half;
    logic [7:0]        byte_v;
    logic              illegal;

    assign widx   = a_addr[ADDR_W-1:2];
    assign lane   = a_addr[1:0];
    assign word   = mem[widx];
    assign half   = lane[1] ? word[31:16] : word[15:0];
    assign byte_v = word[{lane, 3'b000} +: 8];

    always_comb begin
        illegal = 1'b0;
        ld_val  = 32'd0;
        wmask   = 32'd0;
        wval    = 32'd0;
        case (a_digit)
            3'b000: begin
                illegal = (lane != 2'b00);
                ld_val  = word;
                wmask   = 32'hFFFF_FFFF;
                wval    = a_din;
            end
            3'b001, 3'b010: begin
                illegal = lane[0];
                ld_val  = (a_digit == 3'b001) ? {{16{half[15]}}, half} : {16'd0, half};
                wmask   = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wval    = {2{a_din[15:0]}};
            end
            3'b011, 3'b100: begin
                ld_val  = (a_digit == 3'b011) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                wmask   = 32'h0000_00FF << {lane, 3'b000};
                wval    = {4{a_din[7:0]}};
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (access && a_we && !illegal)
            mem[widx] <= (word & ~wmask) | (wval & wmask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            digit_q <= 3'd0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q    <= we;
                addr_q  <= addr;
                din_q   <= din;
                digit_q <= digit;
            end
            if (access) begin
                dout_q <= (illegal || a_we) ? 32'd0 : ld_val;
                err_q  <= illegal;
            end else if (state_q == S_RESP) begin
                dout_q <= 32'd0;
                err_q  <= 1'b0;
            end
        end
    end

    assign ready = (state_q == S_RESP);
    assign dout  = dout_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a vector table of loads/stores on a
// two-wait-state instance plus hand sequences for handshake and reset corners.
module tb_dm_responder;

    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [2:0]  digit;
    logic        ready;
    logic [31:0] dout;
    logic        err;

    logic        req0, we0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [2:0]  digit0;
    logic        ready0;
    logic [31:0] dout0;
    logic        err0;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(9), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .din(din),
        .digit(digit), .ready(ready), .dout(dout), .err(err)
    );

    dm_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .din(din0),
        .digit(digit0), .ready(ready0), .dout(dout0), .err(err0)
    );

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [2:0]  digit;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, wait (bounded) for ready, then confirm outputs clear.
    task automatic run_req(input vec_t v, output logic [31:0] d, output logic e, output int lat);
        we = v.we; addr = v.addr; din = v.din; digit = v.digit; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; addr = 9'h1AB; din = 32'hFFFF_FFFF; digit = 3'b111;
        lat = 1;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = dout;
        e = err;
        @(posedge clk); #1;
        chk("ready_after_resp", {31'd0, ready}, 32'd0);
        chk("dout_after_resp", dout, 32'd0);
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;
    logic        exp0 [7];

    initial begin
        reset = 1'b1;
        req = 0; we = 0; addr = 0; din = 0; digit = 0;
        req0 = 0; we0 = 0; addr0 = 0; din0 = 0; digit0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready0", {31'd0, ready0}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //               we    addr     din            digit   exp_dout       err
        vecs.push_back('{1'b1, 9'h010, 32'h1234_5678, 3'b000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 9'h010, 32'h0000_0000, 3'b000, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 9'h020, 32'h80FF_7F01, 3'b000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 9'h023, 32'h0000_0000, 3'b011, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 9'h023, 32'h0000_0000, 3'b100, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 9'h022, 32'h0000_0000, 3'b001, 32'hFFFF_80FF, 1'b0});
        vecs.push_back('{1'b0, 9'h020, 32'h0000_0000, 3'b010, 32'h0000_7F01, 1'b0});
        vecs.push_back('{1'b1, 9'h030, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 9'h031, 32'h1234_56AB, 3'b100, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 9'h032, 32'h9876_CDEF, 3'b001, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 9'h030, 32'h0000_0000, 3'b000, 32'hCDEF_AB00, 1'b0});
        vecs.push_back('{1'b1, 9'h040, 32'hA5A5_A5A5, 3'b000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 9'h041, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 9'h043, 32'h0000_FFFF, 3'b001, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 9'h040, 32'h0000_0000, 3'b000, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{1'b0, 9'h040, 32'h0000_0000, 3'b110, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 9'h040, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 9'h040, 32'h0000_0000, 3'b000, 32'hA5A5_A5A5, 1'b0});
        vecs.push_back('{1'b0, 9'h041, 32'h0000_0000, 3'b100, 32'h0000_00A5, 1'b0});
        vecs.push_back('{1'b1, 9'h1FC, 32'hC3B2_A190, 3'b000, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 9'h1FF, 32'h0000_0000, 3'b011, 32'hFFFF_FFC3, 1'b0});
        vecs.push_back('{1'b0, 9'h1FE, 32'h0000_0000, 3'b010, 32'h0000_C3B2, 1'b0});
        vecs.push_back('{1'b1, 9'h050, 32'h1111_1111, 3'b000, 32'h0000_0000, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i], d, e, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(WAITS + 1));
            chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            if (!vecs[i].we)
                chk($sformatf("v%0d_dout", i), d, vecs[i].exp_dout);
        end

        // req toggled during WAIT must neither add a response nor disturb the latched address.
        we = 0; addr = 9'h010; digit = 3'b000; req = 1'b1;
        @(posedge clk); #1;
        addr = 9'h020; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; addr = 9'h030;
        @(posedge clk); #1;
        chk("tog_ready", {31'd0, ready}, 32'd1);
        chk("tog_dout", dout, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tog_noextra%0d", k), {31'd0, ready}, 32'd0);
        end

        // Reset during WAIT aborts a pending store.
        we = 1; addr = 9'h050; din = 32'hDEAD_BEEF; digit = 3'b000; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_dout", dout, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_noready%0d", k), {31'd0, ready}, 32'd0);
        end
        run_req('{1'b0, 9'h050, 32'h0, 3'b000, 32'h1111_1111, 1'b0}, d, e, lat);
        chk("abort_lat", 32'(lat), 32'(WAITS + 1));
        chk("abort_keep", d, 32'h1111_1111);

        // Zero-wait instance, req held high: store then two loads, ready every other cycle.
        exp0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        we0 = 1; addr0 = 9'h004; din0 = 32'h5A5A_0F0F; digit0 = 3'b000; req0 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hs_ready%0d", k), {31'd0, ready0}, {31'd0, exp0[k]});
            chk($sformatf("hs_err%0d", k), {31'd0, err0}, 32'd0);
            if (exp0[k] && k > 0)
                chk($sformatf("hs_dout%0d", k), dout0, 32'h5A5A_0F0F);
            if (k == 0) we0 = 1'b0;
            if (k == 4) req0 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
